// File: rtl/osd_video_pkg.sv
// Shared OSD video types and PAL timing defaults (16 MHz pixel-side clock), used by the
// sync decoder here and by the DAC-side frame generator.
package osd_video_pkg;

    typedef enum logic [2:0] {
        GLITCH,
        EQ,
        HSYNC,
        BROAD,
        INVALID
    } pulse_class_t;

    typedef enum logic {
        SEARCH,
        LOCKED
    } sync_state_t;

    localparam int PAL_CNT_W        = 11;
    localparam int PAL_LINE_W       = 10;
    localparam int PAL_LINE_CYCLES  = 1024;
    localparam int PAL_MIN_PULSE    = 16;
    localparam int PAL_HSYNC_MIN    = 60;
    localparam int PAL_HSYNC_NOM    = 75;
    localparam int PAL_HSYNC_MAX    = 150;
    localparam int PAL_BROAD_MIN    = 300;
    localparam int PAL_BROAD_NOM    = 437;
    localparam int PAL_BROAD_COUNT  = 3;
    localparam int PAL_LINE_TIMEOUT = 1536;

    // Gap between HSYNC_MAX and BROAD_MIN is deliberately INVALID: such widths mean we are not
    // looking at a PAL source (or the comparator threshold is wrong).
    function automatic pulse_class_t classify_pulse(
        input int w,
        input int min_pulse,
        input int hsync_min,
        input int hsync_max,
        input int broad_min
    );
        pulse_class_t cls;
        if (w < min_pulse)       cls = GLITCH;
        else if (w < hsync_min)  cls = EQ;
        else if (w <= hsync_max) cls = HSYNC;
        else if (w >= broad_min) cls = BROAD;
        else                     cls = INVALID;
        return cls;
    endfunction

endpackage

// File: rtl/sync_pulse_meter.sv
// Synchronises the sync comparator, measures each low pulse and classifies it at the rising edge.
// Latency: class valid 2 cycles after sync_in rises (3 with SYNC_GLITCH_FILTER_EN); no backpressure.
module sync_pulse_meter
    import osd_video_pkg::*;
#(
    parameter int CNT_W     = PAL_CNT_W,
    parameter int MIN_PULSE = PAL_MIN_PULSE,
    parameter int HSYNC_MIN = PAL_HSYNC_MIN,
    parameter int HSYNC_MAX = PAL_HSYNC_MAX,
    parameter int BROAD_MIN = PAL_BROAD_MIN
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sync_in,
    output logic         o_pulse_valid,
    output pulse_class_t o_pulse_class
);

    logic             r_meta;
    logic             r_sync;
    logic             r_sync_d;
    logic [CNT_W-1:0] r_low_cnt;
    logic             w_sync_s;
    logic             w_rise;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_sync_in;
            r_sync <= r_meta;
        end
    end

`ifdef SYNC_GLITCH_FILTER_EN
    logic r_hist1;
    logic r_hist2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hist1 <= 1'b1;
            r_hist2 <= 1'b1;
        end else begin
            r_hist1 <= r_sync;
            r_hist2 <= r_hist1;
        end
    end

    // Majority of three samples: both edges are delayed by one cycle, so widths are preserved.
    assign w_sync_s = (r_sync & r_hist1) | (r_sync & r_hist2) | (r_hist1 & r_hist2);
`else
    assign w_sync_s = r_sync;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync_d  <= 1'b1;
            r_low_cnt <= '0;
        end else begin
            r_sync_d <= w_sync_s;
            if (w_sync_s) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != '1) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    // r_low_cnt still holds the full width in the rise cycle; it clears on the following edge.
    assign w_rise        = w_sync_s & ~r_sync_d;
    assign o_pulse_valid = w_rise;
    assign o_pulse_class = classify_pulse(int'(r_low_cnt), MIN_PULSE, HSYNC_MIN, HSYNC_MAX, BROAD_MIN);

endmodule

// File: rtl/sync_decoder.sv
// Recovers hsync/vsync, line and in-line position, and lock from composite sync; SYNC_GLITCH_FILTER_EN adds a majority filter.
// Latency: strobes 3 cycles after sync_in rises (4 with filter); free-running, no backpressure.
module sync_decoder
    import osd_video_pkg::*;
#(
    parameter int CNT_W        = PAL_CNT_W,
    parameter int MIN_PULSE    = PAL_MIN_PULSE,
    parameter int HSYNC_MIN    = PAL_HSYNC_MIN,
    parameter int HSYNC_MAX    = PAL_HSYNC_MAX,
    parameter int BROAD_MIN    = PAL_BROAD_MIN,
    parameter int BROAD_COUNT  = PAL_BROAD_COUNT,
    parameter int LINE_TIMEOUT = PAL_LINE_TIMEOUT,
    parameter int LINE_W       = PAL_LINE_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_in,
    output logic              hsync,
    output logic              vsync,
    output logic              locked,
    output logic [LINE_W-1:0] line_count,
    output logic [CNT_W-1:0]  x_count
);

    localparam int               BR_W      = $clog2(BROAD_COUNT + 1);
    localparam logic [BR_W-1:0]  L_BR_SAT  = BR_W'(BROAD_COUNT);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(LINE_TIMEOUT);

    logic              w_pulse_valid;
    pulse_class_t      w_pulse_class;

    sync_state_t       r_state;
    sync_state_t       w_state_nxt;
    logic              r_hsync;
    logic              r_vsync;
    logic [BR_W-1:0]   r_broad_run;
    logic [LINE_W-1:0] r_line_count;
    logic [CNT_W-1:0]  r_x_count;
    logic [CNT_W-1:0]  r_since_sync;

    logic              w_event;
    logic              w_timeout;
    logic              w_hsync_nxt;
    logic              w_vsync_nxt;
    logic [BR_W-1:0]   w_broad_nxt;
    logic              w_clr_x;
    logic              w_clr_since;
    logic              w_line_inc;
    logic              w_line_clr;

    sync_pulse_meter #(
        .CNT_W     (CNT_W),
        .MIN_PULSE (MIN_PULSE),
        .HSYNC_MIN (HSYNC_MIN),
        .HSYNC_MAX (HSYNC_MAX),
        .BROAD_MIN (BROAD_MIN)
    ) u_meter (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_sync_in     (sync_in),
        .o_pulse_valid (w_pulse_valid),
        .o_pulse_class (w_pulse_class)
    );

    // Glitches are invisible to everything, including the timeout arbitration below.
    assign w_event   = w_pulse_valid && (w_pulse_class != GLITCH);
    assign w_timeout = (r_state == LOCKED) && (r_since_sync == L_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hsync_nxt = 1'b0;
        w_vsync_nxt = 1'b0;
        w_broad_nxt = r_broad_run;
        w_clr_x     = 1'b0;
        w_clr_since = 1'b0;
        w_line_inc  = 1'b0;
        w_line_clr  = 1'b0;
        if (w_event) begin
            case (w_pulse_class)
                EQ: begin
                    w_clr_since = 1'b1;
                end
                HSYNC: begin
                    w_hsync_nxt = 1'b1;
                    w_clr_x     = 1'b1;
                    w_clr_since = 1'b1;
                    w_broad_nxt = '0;
                    w_line_inc  = (r_state == LOCKED);
                end
                BROAD: begin
                    w_clr_since = 1'b1;
                    if (r_broad_run != L_BR_SAT) begin
                        w_broad_nxt = r_broad_run + 1'b1;
                        if (r_broad_run == L_BR_SAT - 1'b1) begin
                            w_vsync_nxt = 1'b1;
                            w_line_clr  = 1'b1;
                            w_state_nxt = LOCKED;
                        end
                    end
                end
                INVALID: begin
                    w_broad_nxt = '0;
                    w_state_nxt = SEARCH;
                end
                default: ;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = SEARCH;
        end
    end

    // Position counters advance on every cycle in which they are not cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_broad_run  <= '0;
            r_line_count <= '0;
            r_x_count    <= '0;
            r_since_sync <= '0;
        end else begin
            r_hsync     <= w_hsync_nxt;
            r_vsync     <= w_vsync_nxt;
            r_broad_run <= w_broad_nxt;

            if (w_clr_x) begin
                r_x_count <= '0;
            end else if (r_x_count != '1) begin
                r_x_count <= r_x_count + 1'b1;
            end

            if (w_clr_since) begin
                r_since_sync <= '0;
            end else if (r_since_sync != '1) begin
                r_since_sync <= r_since_sync + 1'b1;
            end

            if (w_line_clr || (w_state_nxt == SEARCH)) begin
                r_line_count <= '0;
            end else if (w_line_inc && (r_line_count != '1)) begin
                r_line_count <= r_line_count + 1'b1;
            end
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign locked     = (r_state == LOCKED);
    assign line_count = r_line_count;
    assign x_count    = r_x_count;

endmodule

// File: tb/tb_sync_decoder.sv
// Directed-vector bench for sync_decoder; strobe latency follows SYNC_GLITCH_FILTER_EN.
module tb_sync_decoder;

`ifdef SYNC_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        sync_in = 1'b1;
    logic        hsync;
    logic        vsync;
    logic        locked;
    logic [9:0]  line_count;
    logic [10:0] x_count;

    int vecs   = 0;
    int errs   = 0;
    int hs_cnt = 0;
    int vs_cnt = 0;

    sync_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .hsync      (hsync),
        .vsync      (vsync),
        .locked     (locked),
        .line_count (line_count),
        .x_count    (x_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        if (hsync === 1'b1) hs_cnt++;
        if (vsync === 1'b1) vs_cnt++;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int w);
        sync_in = 1'b0;
        tickn(w);
        sync_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            vecs++;
            if ({hsync, vsync, locked} !== 3'b000 || line_count !== 10'd0 || x_count !== 11'd0) begin
                errs++;
                $display("FAIL reset[%0d]: hsync=%b vsync=%b locked=%b line=%0d x=%0d, want all 0",
                         i, hsync, vsync, locked, line_count, x_count);
            end
        end
        sync_in = 1'b1;
        tick();
        rst = 1'b1;
        tickn(4);
    endtask

    task automatic test_search_lines();
        hs_cnt = 0;
        for (int ln = 0; ln < 3; ln++) begin
            if (ln > 0) begin
                vecs++;
                if (x_count !== 11'(949 - LAT)) begin
                    errs++;
                    $display("FAIL search x_at_fall[%0d]: got %0d want %0d", ln, x_count, 949 - LAT);
                end
            end
            pulse(75);
            for (int k = 1; k <= LAT; k++) begin
                tick();
                vecs++;
                if (hsync !== (k == LAT)) begin
                    errs++;
                    $display("FAIL search hsync_lat[%0d,%0d]: got %b want %b", ln, k, hsync, (k == LAT));
                end
                if (ln > 0 && k == LAT - 1) begin
                    vecs++;
                    if (x_count !== 11'd1023) begin
                        errs++;
                        $display("FAIL search x_end[%0d]: got %0d want 1023", ln, x_count);
                    end
                end
            end
            vecs++;
            if (x_count !== 11'd0 || line_count !== 10'd0 || locked !== 1'b0) begin
                errs++;
                $display("FAIL search at_hsync[%0d]: x=%0d line=%0d locked=%b, want 0/0/0",
                         ln, x_count, line_count, locked);
            end
            tickn(949 - LAT);
        end
        vecs++;
        if (hs_cnt != 3) begin
            errs++;
            $display("FAIL search hsync_count: got %0d want 3", hs_cnt);
        end
    endtask

    task automatic test_vsync_lock();
        int v0;
        logic v_at;
        for (int b = 0; b < 5; b++) begin
            v0 = vs_cnt;
            v_at = 1'b0;
            pulse(437);
            for (int k = 1; k <= 75; k++) begin
                tick();
                if (k == LAT) v_at = vsync;
            end
            vecs++;
            if ((vs_cnt - v0) != ((b == 2) ? 1 : 0) || locked !== (b >= 2) || line_count !== 10'd0) begin
                errs++;
                $display("FAIL broad[%0d]: vsyncs=%0d locked=%b line=%0d, want %0d/%b/0",
                         b, vs_cnt - v0, locked, line_count, (b == 2) ? 1 : 0, (b >= 2));
            end
            if (b == 2) begin
                vecs++;
                if (v_at !== 1'b1) begin
                    errs++;
                    $display("FAIL vsync_latency: vsync=%b at cycle %0d, want 1", v_at, LAT);
                end
            end
        end
        for (int j = 1; j <= 3; j++) begin
            pulse(75);
            tickn(LAT);
            vecs++;
            if (hsync !== 1'b1 || line_count !== 10'(j) || x_count !== 11'd0) begin
                errs++;
                $display("FAIL locked_line[%0d]: hsync=%b line=%0d x=%0d, want 1/%0d/0",
                         j, hsync, line_count, x_count, j);
            end
            tickn(949 - LAT);
        end
    endtask

    task automatic test_glitch_eq();
        int t = 949 - LAT;
        int h0;
        tickn(100);
        t += 100;
        h0 = hs_cnt;
        pulse(8);
        tickn(6);
        t += 14;
        vecs++;
        if (hs_cnt != h0 || x_count !== 11'(t) || line_count !== 10'd3 || locked !== 1'b1) begin
            errs++;
            $display("FAIL glitch8: hsyncs=%0d x=%0d line=%0d locked=%b, want 0/%0d/3/1",
                     hs_cnt - h0, x_count, line_count, locked, t);
        end
        sync_in = 1'b0;
        tick();
        sync_in = 1'b1;
        tickn(6);
        t += 7;
        vecs++;
        if (hs_cnt != h0 || x_count !== 11'(t) || line_count !== 10'd3) begin
            errs++;
            $display("FAIL spike1: hsyncs=%0d x=%0d line=%0d, want 0/%0d/3", hs_cnt - h0, x_count, line_count, t);
        end
        pulse(59);
        tickn(6);
        t += 65;
        vecs++;
        if (hs_cnt != h0 || x_count !== 11'(t) || line_count !== 10'd3 || locked !== 1'b1) begin
            errs++;
            $display("FAIL eq59: hsyncs=%0d x=%0d line=%0d locked=%b, want 0/%0d/3/1",
                     hs_cnt - h0, x_count, line_count, locked, t);
        end
        pulse(60);
        tickn(LAT - 1);
        vecs++;
        if (hsync !== 1'b0) begin
            errs++;
            $display("FAIL hsync60_early: got %b want 0", hsync);
        end
        tick();
        vecs++;
        if (hsync !== 1'b1 || line_count !== 10'd4 || x_count !== 11'd0) begin
            errs++;
            $display("FAIL hsync60: hsync=%b line=%0d x=%0d, want 1/4/0", hsync, line_count, x_count);
        end
    endtask

    task automatic test_timeout();
        int h0 = hs_cnt;
        tickn(1536);
        vecs++;
        if (locked !== 1'b1 || x_count !== 11'd1536 || line_count !== 10'd4) begin
            errs++;
            $display("FAIL timeout_before: locked=%b x=%0d line=%0d, want 1/1536/4", locked, x_count, line_count);
        end
        tick();
        vecs++;
        if (locked !== 1'b0) begin
            errs++;
            $display("FAIL timeout_edge: locked=%b want 0", locked);
        end
        tickn(63);
        vecs++;
        if (hs_cnt != h0 || locked !== 1'b0) begin
            errs++;
            $display("FAIL timeout_after: hsyncs=%0d locked=%b, want 0/0", hs_cnt - h0, locked);
        end
    endtask

    task automatic test_invalid();
        int v0 = vs_cnt;
        for (int b = 0; b < 3; b++) begin
            pulse(437);
            tickn(75);
        end
        vecs++;
        if (vs_cnt != v0 + 1 || locked !== 1'b1 || line_count !== 10'd0) begin
            errs++;
            $display("FAIL relock: vsyncs=%0d locked=%b line=%0d, want 1/1/0", vs_cnt - v0, locked, line_count);
        end
        pulse(200);
        tickn(LAT - 1);
        vecs++;
        if (locked !== 1'b1) begin
            errs++;
            $display("FAIL invalid200_early: locked=%b want 1", locked);
        end
        tick();
        vecs++;
        if (locked !== 1'b0 || hsync !== 1'b0) begin
            errs++;
            $display("FAIL invalid200: locked=%b hsync=%b, want 0/0", locked, hsync);
        end
        tickn(75);
        v0 = vs_cnt;
        for (int b = 0; b < 2; b++) begin
            pulse(437);
            tickn(75);
        end
        vecs++;
        if (vs_cnt != v0 || locked !== 1'b0) begin
            errs++;
            $display("FAIL broad_run_cleared_2: vsyncs=%0d locked=%b, want 0/0", vs_cnt - v0, locked);
        end
        pulse(437);
        tickn(75);
        vecs++;
        if (vs_cnt != v0 + 1 || locked !== 1'b1) begin
            errs++;
            $display("FAIL broad_run_cleared_3: vsyncs=%0d locked=%b, want 1/1", vs_cnt - v0, locked);
        end
        pulse(150);
        tickn(LAT);
        vecs++;
        if (hsync !== 1'b1 || line_count !== 10'd1 || locked !== 1'b1) begin
            errs++;
            $display("FAIL hsync150: hsync=%b line=%0d locked=%b, want 1/1/1", hsync, line_count, locked);
        end
        tickn(200);
        pulse(151);
        tickn(LAT);
        vecs++;
        if (hsync !== 1'b0 || locked !== 1'b0) begin
            errs++;
            $display("FAIL invalid151: hsync=%b locked=%b, want 0/0", hsync, locked);
        end
        tickn(20);
    endtask

    initial begin
        test_reset();
        test_search_lines();
        test_vsync_lock();
        test_glitch_eq();
        test_timeout();
        test_invalid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
